// File: rtl/out_layer_sched_pkg.sv
// ----------------------------------------------------------------------------
// out_layer_sched_pkg
// Shared definitions for the output-layer scheduler:
//   - default array geometry (neuron count, potential width)
//   - firing threshold (3.6667 in Q12) and time units per image
//   - scheduler FSM state encoding
// ----------------------------------------------------------------------------
package out_layer_sched_pkg;

    localparam int DEF_N       = 8;
    localparam int DEF_W       = 24;
    localparam int DEF_TH      = 15018;
    localparam int DEF_T_STEPS = 200;
    localparam int DEF_TW      = 8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_WAIT_IP,
        S_DISPATCH,
        S_LI_COLLECT,
        S_LI_RESOLVE,
        S_COLLECT,
        S_ADV,
        S_DONE
    } state_t;

endpackage

// File: rtl/out_layer_sched_li_argmax.sv
// ----------------------------------------------------------------------------
// li_argmax
// Lateral-inhibition arbiter: among N latched signed potentials, picks the
// largest one that reaches the threshold TH. Ties resolve to the lowest index.
// Purely combinational.
// Ports:
//   pot   in  N*W  latched potentials, neuron i at bits [i*W +: W]
//   found out 1    at least one potential >= TH
//   idx   out IW   index of the winning neuron (0 when found = 0)
// ----------------------------------------------------------------------------
module li_argmax
    import out_layer_sched_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int W  = DEF_W,
    parameter int TH = DEF_TH,
    localparam int IW = $clog2(N)
) (
    input  logic [N*W-1:0] pot,
    output logic           found,
    output logic [IW-1:0]  idx
);

    localparam logic signed [W-1:0] TH_S = W'(TH);

    logic signed [W-1:0] pot_s [N];
    logic signed [W-1:0] best;

    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign pot_s[gi] = pot[gi*W +: W];
    end

    // Strict '>' when updating keeps the earliest index on equal maxima.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        best  = '0;
        for (int i = 0; i < N; i++) begin
            if ((pot_s[i] >= TH_S) && (!found || (pot_s[i] > best))) begin
                found = 1'b1;
                best  = pot_s[i];
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/out_layer_sched.sv
// ----------------------------------------------------------------------------
// out_layer_sched
// Per-image scheduler for N output neurons. Each time unit it accepts one
// input-spike summary, broadcasts the matching isor start pulse with the
// current li flag, optionally runs lateral-inhibition arbitration, collects
// every neuron's done pulse and advances the time-unit counter. After
// T_STEPS time units it pulses img_done; the winner stays visible until the
// next image starts.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start_img                 begin a new image (only honoured in IDLE)
//   ip_valid, ip_any, ip_ready  input-summary handshake
//   start_li, potential       per-neuron LI requests and signed potentials
//   valid_nu, spike_op_nu     per-neuron done pulses and spike flags
//   start_core_img            image-start pulse to the neurons
//   isor_0_start/isor_1_start time-unit start without/with input spike
//   li                        a winner already exists in this image
//   valid_li, won_lost        arbitration result pulse and vector
//   TU_incre, img_done        end of time unit / end of image pulses
//   winner_valid, winner_idx  image winner, held until next start_img
//   busy                      scheduler not idle
// ----------------------------------------------------------------------------
module out_layer_sched
    import out_layer_sched_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int W       = DEF_W,
    parameter int TH      = DEF_TH,
    parameter int T_STEPS = DEF_T_STEPS,
    parameter int TW      = DEF_TW,
    localparam int IW     = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_img,
    input  logic           ip_valid,
    input  logic           ip_any,
    output logic           ip_ready,
    input  logic [N-1:0]   start_li,
    input  logic [N*W-1:0] potential,
    input  logic [N-1:0]   valid_nu,
    input  logic [N-1:0]   spike_op_nu,
    output logic           start_core_img,
    output logic           isor_0_start,
    output logic           isor_1_start,
    output logic           li,
    output logic           valid_li,
    output logic [N-1:0]   won_lost,
    output logic           TU_incre,
    output logic           img_done,
    output logic           winner_valid,
    output logic [IW-1:0]  winner_idx,
    output logic           busy
);

    state_t          state_reg, state_next;
    logic [TW-1:0]   tu_cnt_reg;
    logic            li_reg;
    logic            ip_any_reg;
    logic [N-1:0]    li_mask_reg;
    logic [N-1:0]    done_mask_reg;
    logic [N-1:0]    spk_vec_reg;
    logic [W-1:0]    pot_q_reg [N];
    logic [N*W-1:0]  pot_q_flat;
    logic            winner_valid_reg;
    logic [IW-1:0]   winner_idx_reg;
    logic            valid_li_reg;
    logic [N-1:0]    won_lost_reg;

    logic            arb_found;
    logic [IW-1:0]   arb_idx;
    logic            collect_en;
    logic            last_tu;
    logic            spk_unused;

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign pot_q_flat[gi*W +: W] = pot_q_reg[gi];
    end

    li_argmax #(.N(N), .W(W), .TH(TH)) u_argmax (
        .pot   (pot_q_flat),
        .found (arb_found),
        .idx   (arb_idx)
    );

    // Done pulses are recorded from the isor pulse onwards so a neuron that
    // finishes while arbitration is still running is never lost.
    assign collect_en = (state_reg == S_DISPATCH)   || (state_reg == S_LI_COLLECT) ||
                        (state_reg == S_LI_RESOLVE) || (state_reg == S_COLLECT);
    assign last_tu    = (tu_cnt_reg == TW'(T_STEPS - 1));

    // The spike vector has no consumer at this level; kept for observability.
    assign spk_unused = ^spk_vec_reg;

    always_comb begin
        state_next     = state_reg;
        ip_ready       = 1'b0;
        start_core_img = 1'b0;
        isor_0_start   = 1'b0;
        isor_1_start   = 1'b0;
        TU_incre       = 1'b0;
        img_done       = 1'b0;
        busy           = (state_reg != S_IDLE);
        case (state_reg)
            S_IDLE:       if (start_img) state_next = S_INIT;
            S_INIT: begin
                start_core_img = 1'b1;
                state_next     = S_WAIT_IP;
            end
            S_WAIT_IP: begin
                ip_ready = 1'b1;
                if (ip_valid) state_next = S_DISPATCH;
            end
            S_DISPATCH: begin
                isor_1_start = ip_any_reg;
                isor_0_start = !ip_any_reg;
                state_next   = (ip_any_reg && !li_reg) ? S_LI_COLLECT : S_COLLECT;
            end
            S_LI_COLLECT: if (&(li_mask_reg | start_li)) state_next = S_LI_RESOLVE;
            S_LI_RESOLVE: state_next = S_COLLECT;
            S_COLLECT:    if (&(done_mask_reg | valid_nu)) state_next = S_ADV;
            S_ADV: begin
                TU_incre   = 1'b1;
                state_next = last_tu ? S_DONE : S_WAIT_IP;
            end
            S_DONE: begin
                img_done   = 1'b1;
                state_next = S_IDLE;
            end
            default:      state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= S_IDLE;
            tu_cnt_reg       <= '0;
            li_reg           <= 1'b0;
            ip_any_reg       <= 1'b0;
            li_mask_reg      <= '0;
            done_mask_reg    <= '0;
            spk_vec_reg      <= '0;
            winner_valid_reg <= 1'b0;
            winner_idx_reg   <= '0;
            valid_li_reg     <= 1'b0;
            won_lost_reg     <= '0;
            for (int i = 0; i < N; i++) pot_q_reg[i] <= '0;
        end else begin
            state_reg    <= state_next;
            valid_li_reg <= 1'b0;
            won_lost_reg <= '0;
            case (state_reg)
                S_INIT: begin
                    tu_cnt_reg       <= '0;
                    li_reg           <= 1'b0;
                    winner_valid_reg <= 1'b0;
                    winner_idx_reg   <= '0;
                    li_mask_reg      <= '0;
                    done_mask_reg    <= '0;
                    spk_vec_reg      <= '0;
                end
                S_WAIT_IP: if (ip_valid) ip_any_reg <= ip_any;
                S_LI_COLLECT: begin
                    li_mask_reg <= li_mask_reg | start_li;
                    // Only the first request of a neuron captures its potential.
                    for (int i = 0; i < N; i++) begin
                        if (start_li[i] && !li_mask_reg[i]) pot_q_reg[i] <= potential[i*W +: W];
                    end
                end
                // Result is registered, so valid_li/won_lost appear in the first
                // COLLECT cycle together with the updated li flag.
                S_LI_RESOLVE: begin
                    valid_li_reg <= 1'b1;
                    if (arb_found) begin
                        won_lost_reg     <= N'(1) << arb_idx;
                        li_reg           <= 1'b1;
                        winner_idx_reg   <= arb_idx;
                        winner_valid_reg <= 1'b1;
                    end else begin
                        won_lost_reg <= '1;
                    end
                end
                S_ADV: begin
                    li_mask_reg   <= '0;
                    done_mask_reg <= '0;
                    spk_vec_reg   <= '0;
                    if (!last_tu) tu_cnt_reg <= tu_cnt_reg + TW'(1);
                end
                default: ;
            endcase
            if (collect_en) begin
                done_mask_reg <= done_mask_reg | valid_nu;
                spk_vec_reg   <= spk_vec_reg | (valid_nu & spike_op_nu);
            end
        end
    end

    assign li           = li_reg;
    assign valid_li     = valid_li_reg;
    assign won_lost     = won_lost_reg;
    assign winner_valid = winner_valid_reg;
    assign winner_idx   = winner_idx_reg;

endmodule

// File: tb/tb_out_layer_sched.sv
// ----------------------------------------------------------------------------
// tb_out_layer_sched
// Scoreboard bench: the stimulus process plays the input stage and the
// neurons, pushes the expected output events (kind, value, cycle) into a
// queue, and a negedge monitor pops and compares every pulse the scheduler
// emits. Arbitration results come from a small reference model of the
// threshold/max/lowest-index rule.
// ----------------------------------------------------------------------------
module tb_out_layer_sched;

    localparam int N       = 8;
    localparam int W       = 24;
    localparam int TH      = 15018;
    localparam int T_STEPS = 3;
    localparam int TW      = 8;
    localparam int IW      = $clog2(N);

    localparam int EV_CORE = 1;
    localparam int EV_ISOR = 2;
    localparam int EV_VLI  = 3;
    localparam int EV_TU   = 4;
    localparam int EV_DONE = 5;

    typedef struct {
        int kind;
        int val;
        int at;
    } ev_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           start_img;
    logic           ip_valid;
    logic           ip_any;
    logic           ip_ready;
    logic [N-1:0]   start_li;
    logic [N*W-1:0] potential;
    logic [N-1:0]   valid_nu;
    logic [N-1:0]   spike_op_nu;
    logic           start_core_img;
    logic           isor_0_start;
    logic           isor_1_start;
    logic           li;
    logic           valid_li;
    logic [N-1:0]   won_lost;
    logic           TU_incre;
    logic           img_done;
    logic           winner_valid;
    logic [IW-1:0]  winner_idx;
    logic           busy;

    out_layer_sched #(.N(N), .W(W), .TH(TH), .T_STEPS(T_STEPS), .TW(TW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_img      (start_img),
        .ip_valid       (ip_valid),
        .ip_any         (ip_any),
        .ip_ready       (ip_ready),
        .start_li       (start_li),
        .potential      (potential),
        .valid_nu       (valid_nu),
        .spike_op_nu    (spike_op_nu),
        .start_core_img (start_core_img),
        .isor_0_start   (isor_0_start),
        .isor_1_start   (isor_1_start),
        .li             (li),
        .valid_li       (valid_li),
        .won_lost       (won_lost),
        .TU_incre       (TU_incre),
        .img_done       (img_done),
        .winner_valid   (winner_valid),
        .winner_idx     (winner_idx),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    ev_t exp_q[$];
    int  pots[N];
    int  dir_dl[N] = '{1, 2, 3, 4, 5, 1, 2, 5};
    bit  li_model;
    bit  win_v_model;
    int  win_idx_model;
    bit  aborted;
    bit  tu_fail;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    int  mon_n;
    ev_t mon_o;
    ev_t mon_e;
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            mon_n = int'(start_core_img) + int'(isor_0_start) + int'(isor_1_start) +
                    int'(valid_li) + int'(TU_incre) + int'(img_done);
            if (mon_n > 1) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pulse_overlap: %0d pulses in cycle %0d, required at most 1", mon_n, cyc);
            end else if (mon_n == 1) begin
                mon_o.at = cyc;
                mon_o.val = 0;
                if (start_core_img) mon_o.kind = EV_CORE;
                else if (isor_0_start || isor_1_start) begin
                    mon_o.kind = EV_ISOR;
                    mon_o.val = (isor_1_start ? 2 : 0) + int'(li);
                end else if (valid_li) begin
                    mon_o.kind = EV_VLI;
                    mon_o.val = int'(won_lost);
                end else if (TU_incre) mon_o.kind = EV_TU;
                else begin
                    mon_o.kind = EV_DONE;
                    mon_o.val = int'(winner_valid) * 16 + int'(winner_idx);
                end
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event: got kind=%0d val=%0d cycle=%0d, required no event",
                             mon_o.kind, mon_o.val, mon_o.at);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_o.kind != mon_e.kind || mon_o.val != mon_e.val || mon_o.at != mon_e.at) begin
                        n_bad++;
                        $display("FAIL event: got kind=%0d val=%0d cycle=%0d, required kind=%0d val=%0d cycle=%0d",
                                 mon_o.kind, mon_o.val, mon_o.at, mon_e.kind, mon_e.val, mon_e.at);
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int kind, input int val, input int at);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic set_pot(input int i, input int v);
        potential[i*W +: W] = v[W-1:0];
    endtask

    task automatic clear_inputs();
        start_img   = 1'b0;
        ip_valid    = 1'b0;
        ip_any      = 1'b0;
        start_li    = '0;
        valid_nu    = '0;
        spike_op_nu = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ip_ready"}, int'(ip_ready), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_start_core_img"}, int'(start_core_img), 0);
        chk({tag, "_isor_0"}, int'(isor_0_start), 0);
        chk({tag, "_isor_1"}, int'(isor_1_start), 0);
        chk({tag, "_li"}, int'(li), 0);
        chk({tag, "_valid_li"}, int'(valid_li), 0);
        chk({tag, "_won_lost"}, int'(won_lost), 0);
        chk({tag, "_TU_incre"}, int'(TU_incre), 0);
        chk({tag, "_img_done"}, int'(img_done), 0);
        chk({tag, "_winner_valid"}, int'(winner_valid), 0);
        chk({tag, "_winner_idx"}, int'(winner_idx), 0);
    endtask

    // Reference: largest potential at or above threshold, lowest index on ties.
    function automatic void ref_arb(output bit found, output int idx);
        int mx;
        found = 1'b0;
        idx   = 0;
        mx    = 0;
        for (int i = 0; i < N; i++) begin
            if (pots[i] >= TH) begin
                if (!found || pots[i] > mx) mx = pots[i];
                found = 1'b1;
            end
        end
        if (found) begin
            for (int i = N - 1; i >= 0; i--) if (pots[i] == mx) idx = i;
        end
    endfunction

    function automatic int rand_pot();
        return int'($urandom_range(0, 50000)) - 30000;
    endfunction

    // ---------------- one time unit ----------------
    task automatic run_tu(input bit any, input int stall, input bit last, input bit abort, input bit directed);
        int k, maxd, e, dupn, maxr, lastc, widx;
        int dl[N];
        int rr[N];
        bit found, do_li;
        logic [N-1:0] rem;
        k = 0;
        while (ip_ready !== 1'b1 && k < 30) begin
            step();
            k++;
        end
        chk("ip_ready_reached", int'(ip_ready), 1);
        if (ip_ready !== 1'b1) begin
            tu_fail = 1'b1;
            return;
        end
        repeat (stall) step();
        if (stall > 0) chk("ip_ready_held_in_stall", int'(ip_ready), 1);
        ip_valid = 1'b1;
        ip_any   = any;
        push(EV_ISOR, (any ? 2 : 0) + (li_model ? 1 : 0), cyc + 1);
        step();
        ip_valid = 1'b0;
        ip_any   = 1'($urandom);
        do_li = any && !li_model;
        rem   = '1;
        if (do_li) begin
            for (int i = 0; i < N; i++) set_pot(i, pots[i]);
            maxd = 0;
            for (int i = 0; i < N; i++) begin
                dl[i] = directed ? dir_dl[i] : int'($urandom_range(1, 5));
                if (dl[i] > maxd) maxd = dl[i];
            end
            e = int'($urandom_range(0, N - 1));
            rem[e] = 1'b0;
            dupn = -1;
            for (int i = 0; i < N; i++) if (dl[i] < maxd && dupn < 0) dupn = i;
            for (int off = 1; off <= maxd; off++) begin
                step();
                start_li    = '0;
                valid_nu    = '0;
                spike_op_nu = '0;
                for (int i = 0; i < N; i++) if (dl[i] == off) start_li[i] = 1'b1;
                // repeat request with a bogus potential must not replace the latch
                if (dupn >= 0 && dl[dupn] + 1 == off) begin
                    start_li[dupn] = 1'b1;
                    set_pot(dupn, 100000);
                end
                if (off == 1) begin
                    valid_nu[e]    = 1'b1;
                    spike_op_nu[e] = 1'($urandom);
                end
            end
            lastc = cyc;
            ref_arb(found, widx);
            push(EV_VLI, found ? (1 << widx) : ((1 << N) - 1), lastc + 2);
            if (found) begin
                li_model      = 1'b1;
                win_v_model   = 1'b1;
                win_idx_model = widx;
            end
            step();
            clear_inputs();
            step();
        end else begin
            step();
        end
        if (abort) begin
            rst = 1'b1;
            #1;
            chk_all_zero("async_reset");
            exp_q.delete();
            clear_inputs();
            step();
            rst = 1'b0;
            aborted = 1'b1;
            return;
        end
        // out-of-state requests that must be ignored
        ip_valid  = 1'b1;
        start_li  = N'($urandom);
        start_img = 1'b1;
        maxr = 0;
        for (int i = 0; i < N; i++) begin
            rr[i] = int'($urandom_range(0, 2));
            if (rem[i] && rr[i] > maxr) maxr = rr[i];
        end
        for (int off = 0; off <= maxr; off++) begin
            if (off > 0) begin
                step();
                clear_inputs();
            end
            valid_nu = '0;
            for (int i = 0; i < N; i++) if (rem[i] && rr[i] == off) valid_nu[i] = 1'b1;
            spike_op_nu = valid_nu & N'($urandom);
            if (off == maxr) begin
                push(EV_TU, 0, cyc + 1);
                if (last) push(EV_DONE, (win_v_model ? 16 : 0) + win_idx_model, cyc + 2);
            end
        end
        step();
        clear_inputs();
    endtask

    // ---------------- one image ----------------
    task automatic run_img(input int mode, input int abort_tu);
        int k;
        bit any, directed;
        int stall;
        k = 0;
        while (busy !== 1'b0 && k < 40) begin
            step();
            k++;
        end
        chk("idle_before_image", int'(busy), 0);
        li_model      = 1'b0;
        win_v_model   = 1'b0;
        win_idx_model = 0;
        aborted       = 1'b0;
        tu_fail       = 1'b0;
        start_img = 1'b1;
        push(EV_CORE, 0, cyc + 1);
        step();
        chk("busy_after_start", int'(busy), 1);
        step();                 // start_img still high in INIT: must be ignored
        start_img = 1'b0;
        for (int t = 0; t < T_STEPS; t++) begin
            directed = 1'b0;
            stall    = 0;
            for (int i = 0; i < N; i++) pots[i] = rand_pot();
            case (mode)
                0: begin
                    any   = 1'b0;
                    stall = (t == 0) ? 10 : 0;
                end
                1: begin
                    any = (t < 2);
                    if (t == 0) begin
                        directed = 1'b1;
                        pots = '{16000, 20000, 20000, -5, 1000, -20000, 15017, 0};
                    end
                end
                2: begin
                    any = (t < 2) ? 1'b1 : 1'($urandom);
                    if (t == 0) begin
                        for (int i = 0; i < N; i++) pots[i] = int'($urandom_range(0, 45017)) - 30000;
                        pots[N-1] = 15017;
                    end else begin
                        pots[$urandom_range(0, N - 1)] = 15018;
                    end
                end
                default: begin
                    any   = (t == abort_tu) ? 1'b0 : 1'($urandom);
                    stall = int'($urandom_range(0, 3));
                end
            endcase
            run_tu(any, stall, t == T_STEPS - 1, t == abort_tu, directed);
            if (aborted || tu_fail) return;
        end
        step();
        step();
        chk("winner_valid_held", int'(winner_valid), int'(win_v_model));
        chk("winner_idx_held", int'(winner_idx), win_idx_model);
        chk("li_held", int'(li), int'(li_model));
        chk("idle_after_image", int'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        potential = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        step();
        run_img(0, -1);          // no input spikes, 10-cycle handshake stall
        run_img(1, -1);          // directed winner, later isor_1 skips LI
        run_img(2, -1);          // no candidate first, LI repeats
        run_img(3, 1);           // reset in COLLECT of the second time unit
        run_img(0, -1);          // clean image right after reset
        for (int r = 0; r < 8; r++) run_img(3, -1);
        repeat (5) step();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
